// File: rtl/imem_uart_loader.sv
// imem_uart_loader: receives a program image over an 8N1 UART line and writes
// it word by word into the instruction memory, holding the CPU in reset until
// the image is complete. Image: A5, count (16-bit LE), then count words (LE).
module imem_uart_loader #(
    parameter int          CLKS_PER_BIT = 868,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int          DEPTH        = 16384
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        uart_rx,
    output logic        imem_wen,
    output logic [31:0] imem_wadr,
    output logic [31:0] imem_wdat,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        load_err,
    output logic [15:0] words_loaded
);

    localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [16:0]      DEPTH_W   = 17'(DEPTH);

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    localparam logic [2:0] LD_SYNC   = 3'd0;
    localparam logic [2:0] LD_CNT_LO = 3'd1;
    localparam logic [2:0] LD_CNT_HI = 3'd2;
    localparam logic [2:0] LD_DATA   = 3'd3;
    localparam logic [2:0] LD_DONE   = 3'd4;

    // Receiver state
    logic             sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
    logic [1:0]       rx_state_q, rx_state_d;
    logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             rx_valid_q, rx_valid_d, rx_ferr_q, rx_ferr_d;

    // Loader state
    logic [2:0]  ld_state_q, ld_state_d;
    logic [15:0] count_q, count_d, consumed_q, consumed_d, words_q, words_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [31:0] asm_q, asm_d, addr_q, addr_d, wadr_q, wadr_d, wdat_q, wdat_d;
    logic        wen_q, wen_d, word_q, word_d, err_q, err_d;

    // Receiver next state: synchroniser, start qualification, bit-centre sampling
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        sync1_d    = uart_rx;
        sync2_d    = sync1_q;
        prev_d     = sync2_q;
        rx_state_d = rx_state_q;
        clk_cnt_d  = clk_cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        rx_valid_d = 1'b0;
        rx_ferr_d  = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (prev_q && !sync2_q) begin
                    rx_state_d = RX_START;
                    clk_cnt_d  = '0;
                end
            end
            RX_START: begin
                if (clk_cnt_q == HALF_LAST) begin
                    // A start bit that is high again at mid-bit was a glitch.
                    clk_cnt_d  = '0;
                    bit_idx_d  = 3'd0;
                    rx_state_d = sync2_q ? RX_IDLE : RX_DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (clk_cnt_q == BIT_LAST) begin
                    clk_cnt_d = '0;
                    shift_d   = {sync2_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) rx_state_d = RX_STOP;
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                if (clk_cnt_q == BIT_LAST) begin
                    clk_cnt_d  = '0;
                    rx_state_d = RX_IDLE;
                    rx_valid_d = sync2_q;
                    rx_ferr_d  = !sync2_q;
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
        endcase
    end

    // Receiver registers; the line idles high so the synchroniser resets to 1
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
        if (!reset) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            prev_q     <= 1'b1;
            rx_state_q <= RX_IDLE;
            clk_cnt_q  <= '0;
            bit_idx_q  <= 3'd0;
            shift_q    <= 8'd0;
            rx_valid_q <= 1'b0;
            rx_ferr_q  <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            prev_q     <= prev_d;
            rx_state_q <= rx_state_d;
            clk_cnt_q  <= clk_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            rx_valid_q <= rx_valid_d;
            rx_ferr_q  <= rx_ferr_d;
        end
    end

    // Loader next state: image parsing, word assembly, write strobe, bookkeeping
    always_comb begin
        ld_state_d = ld_state_q;
        count_d    = count_q;
        consumed_d = consumed_q;
        words_d    = words_q;
        byte_idx_d = byte_idx_q;
        asm_d      = asm_q;
        addr_d     = addr_q;
        wadr_d     = wadr_q;
        wdat_d     = wdat_q;
        err_d      = err_q;
        wen_d      = 1'b0;
        word_d     = 1'b0;

        // The cycle after a word completes: advance counters, maybe finish.
        if (word_q) begin
            consumed_d = consumed_q + 16'd1;
            if (wen_q) begin
                words_d = words_q + 16'd1;
                addr_d  = addr_q + 32'd4;
            end
            if (consumed_q + 16'd1 == count_q) ld_state_d = LD_DONE;
        end

        if (rx_ferr_q && ld_state_q != LD_DONE) begin
            err_d      = 1'b1;
            ld_state_d = LD_SYNC;
            byte_idx_d = 2'd0;
            asm_d      = 32'd0;
        end else if (rx_valid_q) begin
            case (ld_state_q)
                LD_SYNC: begin
                    if (shift_q == 8'hA5) begin
                        words_d    = 16'd0;
                        consumed_d = 16'd0;
                        byte_idx_d = 2'd0;
                        addr_d     = BASE_ADDR;
                        ld_state_d = LD_CNT_LO;
                    end
                end
                LD_CNT_LO: begin
                    count_d[7:0] = shift_q;
                    ld_state_d   = LD_CNT_HI;
                end
                LD_CNT_HI: begin
                    count_d[15:8] = shift_q;
                    ld_state_d    = ({shift_q, count_q[7:0]} == 16'd0) ? LD_DONE : LD_DATA;
                end
                LD_DATA: begin
                    asm_d      = {shift_q, asm_q[31:8]};
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        word_d = 1'b1;
                        if ({1'b0, words_q} >= DEPTH_W) begin
                            err_d = 1'b1;
                        end else begin
                            wen_d  = 1'b1;
                            wadr_d = addr_q;
                            wdat_d = {shift_q, asm_q[31:8]};
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Loader registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ld_state_q <= LD_SYNC;
            count_q    <= 16'd0;
            consumed_q <= 16'd0;
            words_q    <= 16'd0;
            byte_idx_q <= 2'd0;
            asm_q      <= 32'd0;
            addr_q     <= BASE_ADDR;
            wadr_q     <= BASE_ADDR;
            wdat_q     <= 32'd0;
            err_q      <= 1'b0;
            wen_q      <= 1'b0;
            word_q     <= 1'b0;
        end else begin
            ld_state_q <= ld_state_d;
            count_q    <= count_d;
            consumed_q <= consumed_d;
            words_q    <= words_d;
            byte_idx_q <= byte_idx_d;
            asm_q      <= asm_d;
            addr_q     <= addr_d;
            wadr_q     <= wadr_d;
            wdat_q     <= wdat_d;
            err_q      <= err_d;
            wen_q      <= wen_d;
            word_q     <= word_d;
        end
    end

    assign imem_wen     = wen_q;
    assign imem_wadr    = wadr_q;
    assign imem_wdat    = wdat_q;
    assign load_done    = (ld_state_q == LD_DONE);
    assign cpu_hold     = (ld_state_q != LD_DONE);
    assign load_err     = err_q;
    assign words_loaded = words_q;

endmodule

// File: doc/imem_uart_loader.md
# imem_uart_loader

Boot loader that receives a program image over a UART serial line and writes it, word by word, into the instruction memory. It is the write side of the instruction-memory port that the CPU only reads. It holds the CPU in reset until the image is complete, then releases it. It sits in the top level beside the CPU, the program ROM and the data memory, and drives the program ROM's write port.

## Interface
Parameters:
- CLKS_PER_BIT, default 868: clock cycles per UART bit (100 MHz / 115200). Must be ≥ 4.
- BASE_ADDR, default 32'h0000_0000: byte address of the first loaded word. Must be word-aligned.
- DEPTH, default 16384: instruction memory capacity in words.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- uart_rx  in  1  serial input, 8N1, idle high; asynchronous to clk.
- imem_wen  out  1  one-cycle write strobe to instruction memory.
- imem_wadr  out  32  write byte address; word-aligned.
- imem_wdat  out  32  write data.
- cpu_hold  out  1  high keeps the CPU in reset.
- load_done  out  1  sticky; image fully written.
- load_err  out  1  sticky; framing error or overflow seen.
- words_loaded  out  16  count of words written in the current load.

## Operation
- RX front end:
  - uart_rx passes through a 2-flop synchroniser.
  - A falling edge starts a frame. The start bit is re-sampled at CLKS_PER_BIT/2; if it is high, the frame is discarded and the receiver returns to idle.
  - Data bits are sampled at bit centres, LSB first.
  - A high stop bit yields a byte strobe.
  - A low stop bit is a framing error: no byte strobe, load_err set, and the loader FSM returns to SYNC.
- Image format: sync byte 8'hA5, then count N (16-bit, little-endian: low byte first), then N words. Each word is sent as 4 bytes, least-significant byte first.
- Loader FSM states:
  - SYNC: bytes other than 8'hA5 are ignored. On 8'hA5, clear words_loaded and the byte index, set the address to BASE_ADDR, go to CNT_LO.
  - CNT_LO: latch N[7:0], go to CNT_HI.
  - CNT_HI: latch N[15:8]. If N == 0, go to DONE; otherwise go to DATA.
  - DATA:
    - Shift bytes into a 32-bit assembly register; the first byte received lands in bits [7:0].
    - On the 4th byte, pulse imem_wen with the assembled word at the current address.
    - After the write, the address advances by 4, words_loaded increments, and the byte index resets.
    - If words_loaded has reached DEPTH, the word is not written (no imem_wen) but is still counted toward N, and load_err is set.
    - When N words have been consumed, go to DONE.
  - DONE: cpu_hold = 0, load_done = 1. All further bytes are ignored until reset.
- Address arithmetic: 32-bit, wraps modulo 2^32. It cannot wrap in practice because of the DEPTH limit.
- A framing error in any state other than DONE clears the partial word and returns to SYNC. words_loaded keeps its value until the next sync byte. cpu_hold stays high.

## Timing
- Reset values: imem_wen = 0, imem_wadr = BASE_ADDR, imem_wdat = 0, cpu_hold = 1, load_done = 0, load_err = 0, words_loaded = 0. FSM = SYNC, receiver idle.
- Asserting reset mid-load aborts immediately. No write strobe is issued during or after reset.
- Synchroniser latency: 2 cycles.
- Byte strobe: 1 cycle after the stop-bit centre sample.
- imem_wen: high exactly 1 cycle, in the cycle after the 4th byte strobe. imem_wadr and imem_wdat are valid in that same cycle and held until the next write.
- words_loaded updates in the cycle after imem_wen.
- load_done rises and cpu_hold falls in the same cycle:
  - 1 cycle after the last imem_wen (or after the last counted word, if it was dropped for overflow);
  - 1 cycle after the CNT_HI byte strobe when N == 0.
- Back-to-back frames (stop bit immediately followed by start bit) are received without loss.
- A byte strobe never coincides with imem_wen for the same word, so no simultaneous-event hazard exists.

## Test plan
- With CLKS_PER_BIT=4, send A5 02 00 78 56 34 12 EF BE AD DE. Required: two imem_wen pulses with (adr 0x0, dat 0x12345678) and (adr 0x4, dat 0xDEADBEEF); words_loaded = 2; load_done = 1 and cpu_hold = 0 one cycle after the 2nd strobe.
- Send 00 FF A5 00 00. Required: the leading bytes are ignored; no imem_wen; load_done rises 1 cycle after the 5th byte strobe.
- Send A5 01 00 11 22, then one frame with a low stop bit. Required: load_err = 1, no imem_wen, cpu_hold = 1. A following A5 01 00 01 02 03 04 writes 0x04030201 at BASE_ADDR.
- With DEPTH=2, send A5 03 00 and 3 words. Required: 2 writes, load_err = 1, load_done = 1, words_loaded = 2.
- Apply a 1-cycle glitch low on uart_rx (shorter than half a bit). Required: no byte strobe and no state change.
- Assert reset during the 3rd data byte. Required: all outputs return to their reset values asynchronously; a full reload afterwards succeeds starting at BASE_ADDR.
